psum_ofifo: RTL and testbench

- Output buffer directly downstream of mac_array; captures the col-wide partial-sum bus `out` using the per-column `fifo_wr` strobes.
- The array emits its results column-skewed (diagonal wavefront), so each column gets an independent FIFO lane.
- Read side delivers one column-aligned row of col psums at a time.
- Feeds the normalization/SFU stage and the host readout path.

---
 rtl/psum_ofifo.sv | 104 ++++++++++
 tb/tb_psum_ofifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_ofifo.sv
// Per-column psum output FIFO behind mac_array: independent lanes absorb the skewed wavefront, read side pops one aligned row.
// Latency: write visible in status next cycle; accepted rd -> out/out_vld one cycle later.
// Backpressure: none upstream (writes to a full lane are dropped and flagged sticky); rd is ignored unless every lane holds data.
module psum_ofifo #(
  parameter int col     = 8,
  parameter int bw_psum = 22,
  parameter int depth   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw_psum-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   out_vld,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   overflow
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]            wptr_q [col];
  logic [AW:0]            wptr_d [col];
  logic [AW:0]            rptr_q [col];
  logic [AW:0]            rptr_d [col];
  logic [bw_psum-1:0]     mem_q  [col][depth];
  logic [col-1:0]         empty;
  logic [col-1:0]         full;
  logic [col-1:0]         wr_acc;
  logic                   rd_acc;
  logic [col*bw_psum-1:0] out_q;
  logic [col*bw_psum-1:0] out_d;
  logic                   out_vld_q;
  logic                   overflow_q;
  logic                   overflow_d;

  // Per-lane empty/full flags straight from the pointer pair.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < col; i++) begin
      empty[i] = (wptr_q[i] == rptr_q[i]);
      full[i]  = (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]) &&
                 (wptr_q[i][AW] != rptr_q[i][AW]);
    end
  end

  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign rd_acc  = rd & o_valid;
  // A full lane still accepts a write when the same edge pops a row, freeing its slot.
  assign wr_acc  = wr & (~full | {col{rd_acc}});

  // Next-state for pointers, row register and the sticky overflow flag.
  always_comb begin
    out_d      = out_q;
    overflow_d = overflow_q | (|(wr & ~wr_acc));
    for (int i = 0; i < col; i++) begin
      wptr_d[i] = wr_acc[i] ? wptr_q[i] + PTR_ONE : wptr_q[i];
      rptr_d[i] = rd_acc    ? rptr_q[i] + PTR_ONE : rptr_q[i];
      if (rd_acc) begin
        out_d[i*bw_psum +: bw_psum] = mem_q[i][rptr_q[i][AW-1:0]];
      end
    end
  end

  // Control state; async reset drops all queued entries at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < col; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < col; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
      end
      out_q      <= out_d;
      out_vld_q  <= rd_acc;
      overflow_q <= overflow_d;
    end
  end

  // Lane storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (wr_acc[i]) begin
        mem_q[i][wptr_q[i][AW-1:0]] <= in[i*bw_psum +: bw_psum];
      end
    end
  end

  assign out      = out_q;
  assign out_vld  = out_vld_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_psum_ofifo;
  localparam int COL   = 8;
  localparam int BW    = 22;
  localparam int DEPTH = 16;
  localparam int W     = COL*BW;

  logic           clk;
  logic           reset;
  logic [W-1:0]   in_bus;
  logic [W-1:0]   out_bus;
  logic [COL-1:0] wr;
  logic           rd;
  logic           out_vld;
  logic           o_valid;
  logic           o_full;
  logic           overflow;

  psum_ofifo #(.col(COL), .bw_psum(BW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(in_bus), .wr(wr), .rd(rd),
    .out(out_bus), .out_vld(out_vld), .o_valid(o_valid),
    .o_full(o_full), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per lane, last popped row, flags.
  logic [BW-1:0] q       [COL][$];
  logic [BW-1:0] exp_out [COL];
  logic [BW-1:0] ld      [COL];
  logic          m_vld;
  logic          m_ovf;

  typedef struct {
    logic [COL-1:0] w;
    int             base;
    logic           r;
    logic           e_valid;
    logic           e_vld;
    int             e_base;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_exp();
    logic [W-1:0] v;
    for (int i = 0; i < COL; i++) v[i*BW +: BW] = exp_out[i];
    return v;
  endfunction

  function automatic logic [W-1:0] row_val(input int base);
    logic [W-1:0] v;
    for (int i = 0; i < COL; i++) v[i*BW +: BW] = BW'(base + i);
    return v;
  endfunction

  function automatic logic m_valid();
    for (int i = 0; i < COL; i++) if (q[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int i = 0; i < COL; i++) if (q[i].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < COL; i++) begin
      q[i].delete();
      exp_out[i] = '0;
    end
    m_vld = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic set_row(input int base);
    for (int i = 0; i < COL; i++) ld[i] = BW'(base + i);
  endtask

  task automatic check_model();
    chk("out", out_bus, pack_exp());
    chk1("out_vld", out_vld, m_vld);
    chk1("o_valid", o_valid, m_valid());
    chk1("o_full", o_full, m_full());
    chk1("overflow", overflow, m_ovf);
  endtask

  // One clock: drive wr/rd with ld[] as lane data, advance the model, check after the edge.
  task automatic cyc(input logic [COL-1:0] w, input logic r);
    logic racc;
    racc = r && m_valid();
    wr = w;
    rd = r;
    for (int i = 0; i < COL; i++) in_bus[i*BW +: BW] = ld[i];
    if (racc) for (int i = 0; i < COL; i++) exp_out[i] = q[i].pop_front();
    for (int i = 0; i < COL; i++) begin
      if (w[i]) begin
        if (q[i].size() < DEPTH) q[i].push_back(ld[i]);
        else m_ovf = 1'b1;
      end
    end
    m_vld = racc;
    @(posedge clk);
    #1;
    wr = '0;
    rd = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #2;
    check_model();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [COL-1:0] w;
    reset  = 1'b0;
    wr     = '0;
    rd     = 1'b0;
    in_bus = '0;
    for (int i = 0; i < COL; i++) ld[i] = '0;
    model_reset();

    // Reset state
    #12;
    chk("rst_out", out_bus, '0);
    chk1("rst_out_vld", out_vld, 1'b0);
    chk1("rst_o_valid", o_valid, 1'b0);
    chk1("rst_o_full", o_full, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Vector table: partial-lane writes, gated reads, ignored reads
    vt[0] = '{8'hFF, 100, 1'b0, 1'b1, 1'b0, 0};
    vt[1] = '{8'h0F, 200, 1'b0, 1'b1, 1'b0, 0};
    vt[2] = '{8'h00, 0,   1'b1, 1'b0, 1'b1, 100};
    vt[3] = '{8'h00, 0,   1'b1, 1'b0, 1'b0, 0};
    vt[4] = '{8'hF0, 200, 1'b0, 1'b1, 1'b0, 0};
    vt[5] = '{8'h00, 0,   1'b1, 1'b0, 1'b1, 200};
    vt[6] = '{8'h00, 0,   1'b1, 1'b0, 1'b0, 0};
    for (int k = 0; k < 7; k++) begin
      set_row(vt[k].base);
      cyc(vt[k].w, vt[k].r);
      chk1($sformatf("vec%0d_o_valid", k), o_valid, vt[k].e_valid);
      chk1($sformatf("vec%0d_out_vld", k), out_vld, vt[k].e_vld);
      if (vt[k].e_vld) chk($sformatf("vec%0d_out", k), out_bus, row_val(vt[k].e_base));
    end

    // Aligned fill then drain
    for (int r = 0; r < 8; r++) begin
      set_row(100*r);
      cyc(8'hFF, 1'b0);
    end
    cnt = 0;
    for (int r = 0; r < 8; r++) begin
      cyc(8'h00, 1'b1);
      if (out_vld) cnt++;
      chk($sformatf("drain_row%0d", r), out_bus, row_val(100*r));
    end
    chk("drain_pulses", W'(cnt), W'(8));
    chk1("drain_o_valid", o_valid, 1'b0);

    // Skewed wavefront
    for (int t = 0; t < 11; t++) begin
      w = '0;
      for (int i = 0; i < COL; i++) begin
        if (t - i >= 0 && t - i < 4) begin
          w[i]  = 1'b1;
          ld[i] = BW'(1000 + 100*(t-i) + i);
        end
      end
      cyc(w, 1'b0);
      if (t == 6) chk1("skew_before", o_valid, 1'b0);
      if (t == 7) chk1("skew_rise", o_valid, 1'b1);
    end
    for (int r = 0; r < 4; r++) begin
      cyc(8'h00, 1'b1);
      chk($sformatf("skew_row%0d", r), out_bus, row_val(1000 + 100*r));
    end

    // Negative values
    for (int i = 0; i < COL; i++) ld[i] = (i % 2) ? 22'h200000 : 22'h3FFFFF;
    cyc(8'hFF, 1'b0);
    cyc(8'h00, 1'b1);
    chk("neg_lane0", W'(out_bus[BW-1:0]), W'(22'h3FFFFF));
    chk("neg_lane1", W'(out_bus[2*BW-1:BW]), W'(22'h200000));

    // Full, overflow and wrap on lane 0
    for (int k = 0; k < DEPTH + 1; k++) begin
      ld[0] = BW'(5000 + k);
      cyc(8'h01, 1'b0);
      if (k == DEPTH - 1) begin
        chk1("lane0_full", o_full, 1'b1);
        chk1("lane0_no_ovf_yet", overflow, 1'b0);
      end
    end
    chk1("lane0_overflow", overflow, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      set_row(6000 + 10*k);
      cyc(8'hFE, 1'b0);
    end
    for (int k = 0; k < DEPTH; k++) begin
      cyc(8'h00, 1'b1);
      chk($sformatf("lane0_data%0d", k), W'(out_bus[BW-1:0]), W'(5000 + k));
    end
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < DEPTH; k++) begin
        set_row(20000 + 1000*rep + 10*k);
        cyc(8'hFF, 1'b0);
      end
      for (int k = 0; k < DEPTH; k++) cyc(8'h00, 1'b1);
      chk($sformatf("wrap%0d_last", rep), out_bus, row_val(20000 + 1000*rep + 10*(DEPTH-1)));
    end

    // Simultaneous rd/wr at full
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      set_row(300 + 10*k);
      cyc(8'hFF, 1'b0);
    end
    set_row(9000);
    cyc(8'hFF, 1'b1);
    chk1("simul_full", o_full, 1'b1);
    chk1("simul_no_ovf", overflow, 1'b0);
    chk("simul_first", out_bus, row_val(300));
    for (int k = 0; k < DEPTH; k++) cyc(8'h00, 1'b1);
    chk("simul_newest", out_bus, row_val(9000));

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < COL; i++) ld[i] = BW'($urandom);
      w = COL'($urandom);
      cyc(w, 1'($urandom_range(0, 1)));
    end

    // Reset mid-operation
    do_reset();
    for (int r = 0; r < 5; r++) begin
      set_row(4000 + 10*r);
      cyc(8'hFF, 1'b0);
    end
    for (int k = 0; k < 12; k++) begin
      ld[0] = BW'(4500 + k);
      cyc(8'h01, 1'b0);
    end
    cyc(8'h00, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    chk1("mid_rst_o_valid", o_valid, 1'b0);
    chk1("mid_rst_o_full", o_full, 1'b0);
    chk("mid_rst_out", out_bus, '0);
    chk1("mid_rst_out_vld", out_vld, 1'b0);
    chk1("mid_rst_overflow", overflow, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    set_row(7000);
    cyc(8'hFF, 1'b0);
    cyc(8'h00, 1'b1);
    chk("post_rst_row", out_bus, row_val(7000));
    chk1("post_rst_empty", o_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
